// File: rtl/fproc_arbiter.sv
// fproc_arbiter: round-robin sharing of one fproc core between N_DSP_UNIT requesters.
// Request pulses are latched per unit; one request at a time is issued, awaited (with timeout) and returned.
module fproc_arbiter #(
    parameter int N_DSP_UNIT     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int FPROC_ID_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int SW = $clog2(N_DSP_UNIT),
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1
) (
    input  logic                                         clk_i,
    input  logic                                         reset_n_i,
    input  logic [N_DSP_UNIT-1:0]                        req_enable_i,
    input  logic [N_DSP_UNIT-1:0][FPROC_ID_WIDTH-1:0]    req_id_i,
    output logic [N_DSP_UNIT-1:0]                        resp_ready_o,
    output logic [N_DSP_UNIT-1:0][DATA_WIDTH-1:0]        resp_data_o,
    output logic                                         core_enable_o,
    output logic [FPROC_ID_WIDTH-1:0]                    core_id_o,
    output logic [SW-1:0]                                core_src_o,
    input  logic                                         core_ready_i,
    input  logic [DATA_WIDTH-1:0]                        core_data_i,
    input  logic                                         err_clear_i,
    output logic [N_DSP_UNIT-1:0]                        err_overrun_o,
    output logic [N_DSP_UNIT-1:0]                        err_timeout_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                                      state_q;
    logic [N_DSP_UNIT-1:0]                       pend_q, pend_d, ovr_q, ovr_d;
    logic [N_DSP_UNIT-1:0][FPROC_ID_WIDTH-1:0]   id_q, id_d;
    logic [SW-1:0]                               rr_q, grant;
    logic [CW-1:0]                               cnt_q;
    logic                                        found;

    // A fresh pulse always sets pending, even in the cycle its old request is being retired.
    always_comb begin
        pend_d = pend_q;
        id_d   = id_q;
        ovr_d  = err_clear_i ? '0 : ovr_q;
        for (int u = 0; u < N_DSP_UNIT; u++) begin
            if (req_enable_i[u] && pend_q[u] && !(state_q == RESP && core_src_o == SW'(u)))
                ovr_d[u] = 1'b1;
            else if (req_enable_i[u]) begin
                pend_d[u] = 1'b1;
                id_d[u]   = req_id_i[u];
            end else if (state_q == RESP && core_src_o == SW'(u))
                pend_d[u] = 1'b0;
        end
    end

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N_DSP_UNIT; i++) begin
            if (!found && pend_q[(int'(rr_q) + i) % N_DSP_UNIT]) begin
                grant = SW'((int'(rr_q) + i) % N_DSP_UNIT);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pend_q <= '0;
            id_q   <= '0;
            ovr_q  <= '0;
        end else begin
            pend_q <= pend_d;
            id_q   <= id_d;
            ovr_q  <= ovr_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= IDLE;
            rr_q          <= '0;
            cnt_q         <= '0;
            core_enable_o <= 1'b0;
            core_id_o     <= '0;
            core_src_o    <= '0;
            resp_ready_o  <= '0;
            resp_data_o   <= '0;
            err_timeout_o <= '0;
        end else begin
            core_enable_o <= 1'b0;
            resp_ready_o  <= '0;
            if (err_clear_i)
                err_timeout_o <= '0;
            case (state_q)
                IDLE: if (found) begin
                    core_src_o    <= grant;
                    core_id_o     <= id_q[grant];
                    core_enable_o <= 1'b1;
                    state_q       <= ISSUE;
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: if (core_ready_i) begin
                    resp_data_o[core_src_o]  <= core_data_i;
                    resp_ready_o[core_src_o] <= 1'b1;
                    state_q                  <= RESP;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    resp_data_o[core_src_o]   <= '0;
                    resp_ready_o[core_src_o]  <= 1'b1;
                    err_timeout_o[core_src_o] <= 1'b1;
                    state_q                   <= RESP;
                end else
                    cnt_q <= cnt_q + 1'b1;
                default: begin
                    rr_q    <= (core_src_o == SW'(N_DSP_UNIT - 1)) ? '0 : core_src_o + 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign err_overrun_o = ovr_q;
endmodule

// File: tb/tb_fproc_arbiter.sv
// tb_fproc_arbiter: directed scoreboard bench; stimulus queues expected responses, a monitor pops them.
module tb_fproc_arbiter;
    localparam int N = 8, DW = 32, IW = 8, TO = 16, SW = 3;

    logic                   clk = 0, reset_n = 0;
    logic [N-1:0]           req_enable = '0;
    logic [N-1:0][IW-1:0]   req_id = '0;
    logic [N-1:0]           resp_ready;
    logic [N-1:0][DW-1:0]   resp_data;
    logic                   core_enable;
    logic [IW-1:0]          core_id;
    logic [SW-1:0]          core_src;
    logic                   core_ready = 0;
    logic [DW-1:0]          core_data = '0;
    logic                   err_clear = 0;
    logic [N-1:0]           err_overrun, err_timeout;

    fproc_arbiter #(.N_DSP_UNIT(N), .DATA_WIDTH(DW), .FPROC_ID_WIDTH(IW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .req_enable_i(req_enable), .req_id_i(req_id),
        .resp_ready_o(resp_ready), .resp_data_o(resp_data), .core_enable_o(core_enable),
        .core_id_o(core_id), .core_src_o(core_src), .core_ready_i(core_ready),
        .core_data_i(core_data), .err_clear_i(err_clear), .err_overrun_o(err_overrun),
        .err_timeout_o(err_timeout));

    always #5 clk = ~clk;

    typedef struct { int unit; logic [DW-1:0] data; int cyc; } exp_t;
    exp_t q[$];
    int cyc = 0, passed = 0, total = 0, n_en = 0, core_lat = 1;
    logic core_silent = 0, use_fixed = 0;
    logic [DW-1:0] fixed_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic at_cycle(int k);
        forever begin
            @(negedge clk);
            if (cyc >= k) break;
        end
    endtask

    task automatic push(int u, logic [DW-1:0] d, int c);
        exp_t e;
        e.unit = u; e.data = d; e.cyc = c;
        q.push_back(e);
    endtask

    task automatic pulse(logic [N-1:0] m, logic [N-1:0][IW-1:0] ids, output int t);
        @(posedge clk); #1;
        t = cyc;
        req_enable = m;
        req_id = ids;
        @(posedge clk); #1;
        req_enable = '0;
    endtask

    task automatic drain(string name);
        int k = 0;
        while (q.size() != 0 && k < 300) begin @(negedge clk); k++; end
        check(name, 64'(q.size()), 0);
        q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
    endtask

    initial forever begin
        @(negedge clk);
        if (core_enable) n_en++;
    end

    // Core model: answers core_lat cycles after each enable unless silenced
    initial forever begin
        @(negedge clk);
        if (core_enable && !core_silent) begin
            automatic logic [IW-1:0] id = core_id;
            repeat (core_lat) @(posedge clk);
            #1;
            core_ready = 1;
            core_data = use_fixed ? fixed_data : {16'hC0DE, 8'h00, id};
            @(posedge clk); #1;
            core_ready = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset_n && resp_ready != '0) begin
            automatic int u = 0;
            for (int i = N - 1; i >= 0; i--) if (resp_ready[i]) u = i;
            check("resp_onehot", 64'($onehot(resp_ready)), 1);
            if (q.size() == 0) begin
                total++;
                $display("FAIL unexpected_resp: unit %0d data %0h, none expected (cycle %0d)", u, resp_data[u], cyc);
            end else begin
                automatic exp_t e = q.pop_front();
                check("resp_unit", 64'(u), 64'(e.unit));
                check("resp_data", 64'(resp_data[u]), 64'(e.data));
                if (e.cyc >= 0) check("resp_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, e0;
        logic [N-1:0][IW-1:0] ids;
        #1;
        check("reset_outputs", {core_enable, core_id, 5'(core_src), resp_ready, err_overrun, err_timeout}, 0);
        check("reset_data", 64'(|resp_data), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1;

        // 1: single request, unit 3
        use_fixed = 1; fixed_data = 32'hDEADBEEF; core_lat = 3;
        ids = '0; ids[3] = 8'h15;
        @(posedge clk); #1;
        t = cyc;
        push(3, 32'hDEADBEEF, t + 6);
        req_enable = 8'h08; req_id = ids;
        @(posedge clk); #1;
        req_enable = '0;
        at_cycle(t + 1);
        check("t1_no_early_enable", 64'(core_enable), 0);
        at_cycle(t + 2);
        check("t1_core_enable", 64'(core_enable), 1);
        check("t1_core_id", 64'(core_id), 64'h15);
        check("t1_core_src", 64'(core_src), 3);
        drain("t1_drain");
        use_fixed = 0; core_lat = 1;

        // 2: all units at once, grants in order 0..7, 4 cycles per transaction
        do_reset();
        for (int u = 0; u < N; u++) ids[u] = 8'h20 + 8'(u);
        @(posedge clk); #1;
        t = cyc;
        for (int u = 0; u < N; u++) push(u, 32'hC0DE0020 + u, t + 4 + 4 * u);
        req_enable = '1; req_id = ids;
        @(posedge clk); #1;
        req_enable = '0;
        drain("t2_drain");

        // 3: after serving 4, unit 6 beats unit 1
        do_reset();
        ids = '0; ids[4] = 8'h44;
        push(4, 32'hC0DE0044, -1);
        pulse(8'h10, ids, t);
        drain("t3a_drain");
        ids = '0; ids[1] = 8'h11; ids[6] = 8'h61;
        push(6, 32'hC0DE0061, -1);
        push(1, 32'hC0DE0011, -1);
        pulse(8'h42, ids, t);
        drain("t3b_drain");

        // 4: overrun on unit 2 keeps first id
        e0 = n_en;
        ids = '0; ids[2] = 8'h22;
        push(2, 32'hC0DE0022, -1);
        @(posedge clk); #1;
        t = cyc;
        req_enable = 8'h04; req_id = ids;
        @(posedge clk); #1;
        req_id[2] = 8'h99;
        @(posedge clk); #1;
        req_enable = '0;
        at_cycle(t + 2);
        check("t4_overrun_set", 64'(err_overrun), 64'h04);
        drain("t4_drain");
        check("t4_one_core_req", 64'(n_en - e0), 1);
        @(posedge clk); #1 err_clear = 1;
        @(posedge clk); #1 err_clear = 0;
        @(negedge clk);
        check("t4_overrun_clear", 64'(err_overrun), 0);

        // 5: timeout on unit 5, late ready ignored
        core_silent = 1;
        ids = '0; ids[5] = 8'h55;
        @(posedge clk); #1;
        t = cyc;
        push(5, 32'h0, t + 19);
        req_enable = 8'h20; req_id = ids;
        @(posedge clk); #1;
        req_enable = '0;
        at_cycle(t + 18);
        check("t5_no_early_timeout", 64'(err_timeout), 0);
        at_cycle(t + 19);
        check("t5_timeout_flag", 64'(err_timeout), 64'h20);
        @(posedge clk); #1;
        core_ready = 1; core_data = 32'h12345678;
        @(posedge clk); #1;
        core_ready = 0;
        drain("t5_drain");
        check("t5_data_held", 64'(resp_data[5]), 0);
        @(posedge clk); #1 err_clear = 1;
        @(posedge clk); #1 err_clear = 0;
        @(negedge clk);
        check("t5_timeout_clear", 64'(err_timeout), 0);

        // 6: reset during WAIT discards the request
        ids = '0; ids[1] = 8'h31;
        pulse(8'h02, ids, t);
        at_cycle(t + 4);
        check("t6_busy_src", 64'(core_src), 1);
        #1 reset_n = 0;
        #1;
        check("t6_reset_outputs", {core_enable, core_id, 5'(core_src), resp_ready, err_overrun, err_timeout}, 0);
        check("t6_reset_data", 64'(|resp_data), 0);
        @(posedge clk); #1 reset_n = 1;
        repeat (25) @(negedge clk);
        core_silent = 0;
        ids = '0; ids[7] = 8'h77;
        @(posedge clk); #1;
        t = cyc;
        push(7, 32'hC0DE0077, t + 4);
        req_enable = 8'h80; req_id = ids;
        @(posedge clk); #1;
        req_enable = '0;
        drain("t6_drain");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
